// File: rtl/atanh_function_1.sv
// Inverse of the piecewise-linear tanh unit: Q4.9 y in, Q5.5 x out, found by a
// 9-step sequential binary search on |x| against the forward model T.
module atanh_function_1 #(
  parameter int unsigned integer_dataWidth_i  = 4,
  parameter int unsigned fraction_dataWidth_i = 9,
  parameter int unsigned integer_dataWidth_o  = 5,
  parameter int unsigned fraction_dataWidth_o = 5
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              c_en,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [integer_dataWidth_i+fraction_dataWidth_i-1:0] data_in,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [integer_dataWidth_o+fraction_dataWidth_o-1:0] data_out
);

  if (integer_dataWidth_i != 4 || fraction_dataWidth_i != 9 ||
      integer_dataWidth_o != 5 || fraction_dataWidth_o != 5) begin : g_param_check
    $error("atanh_function_1: only the default Q4.9 -> Q5.5 widths are supported");
  end

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [12:0] y_q, y_d;
  logic [8:0]  m_q, m_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  dout_q, dout_d;
  logic        ov_q, ov_d;

  logic [12:0] y_abs;
  logic [8:0]  cand;
  logic [8:0]  m_next;
  logic [9:0]  m_ext;
  logic [9:0]  result;

  // Forward tanh model on a Q5.5 magnitude code, result in Q.9.
  function automatic logic [12:0] t_fwd(input logic [8:0] a);
    logic [12:0] t;
    if (a < 9'd16) begin
      t = {a, 4'b0000};
    end else if (a < 9'd32) begin
      t = {1'b0, a, 3'b000} + 13'd128;
    end else if (a < 9'd64) begin
      t = {3'b000, a, 1'b0} + 13'd320;
    end else if (a < 9'd96) begin
      t = {4'b0000, a} + 13'd384;
    end else begin
      t = 13'd511;
    end
    return t;
  endfunction

  // 13-bit two's complement negate keeps -4096 as magnitude 4096.
  assign y_abs  = data_in[12] ? (~data_in + 13'd1) : data_in;
  assign cand   = m_q | (9'd1 << bit_q);
  assign m_next = (t_fwd(cand) <= y_q) ? cand : m_q;
  assign m_ext  = {1'b0, m_next};
  assign result = sign_q ? (~m_ext + 10'd1) : m_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      y_q     <= '0;
      m_q     <= '0;
      bit_q   <= '0;
      dout_q  <= '0;
      ov_q    <= 1'b0;
    end else if (c_en) begin
      state_q <= state_d;
      sign_q  <= sign_d;
      y_q     <= y_d;
      m_q     <= m_d;
      bit_q   <= bit_d;
      dout_q  <= dout_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = StSearch;
      StSearch: if (bit_q == 4'd0) state_d = StDone;
      StDone:   if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    sign_d = sign_q;
    y_d    = y_q;
    m_d    = m_q;
    bit_d  = bit_q;
    dout_d = dout_q;
    ov_d   = ov_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = data_in[12];
          y_d    = y_abs;
          m_d    = '0;
          bit_d  = 4'd8;
        end
      end
      StSearch: begin
        m_d = m_next;
        if (bit_q == 4'd0) begin
          dout_d = result;
          ov_d   = 1'b1;
        end else begin
          bit_d = bit_q - 4'd1;
        end
      end
      StDone: begin
        if (out_ready) ov_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = ov_q;
    data_out  = dout_q;
  end

endmodule

// File: tb/tb_atanh_function_1.sv
// Bench for atanh_function_1: directed corner cases plus random transactions,
// each checked against a brute-force scan of the forward tanh model.
module tb_atanh_function_1;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_en;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  data_out;

  int n_cmp = 0;
  int n_err = 0;

  atanh_function_1 dut (
    .clk      (clk),
    .reset    (reset),
    .c_en     (c_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int t_ref(input int a);
    if (a < 16) return 16 * a;
    if (a < 32) return 8 * a + 128;
    if (a < 64) return 2 * a + 320;
    if (a < 96) return a + 384;
    return 511;
  endfunction

  // Largest magnitude code whose forward value does not exceed |y|.
  function automatic logic [9:0] atanh_ref(input logic [12:0] y);
    int v, mag, best;
    v    = int'($signed(y));
    mag  = (v < 0) ? -v : v;
    best = 0;
    for (int a = 0; a < 512; a++) if (t_ref(a) <= mag) best = a;
    return (v < 0) ? 10'(-best) : 10'(best);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [12:0] din, input int stall_at, input int stall_len,
                         input int bp_cycles);
    logic [9:0] exp_out;
    int         lat;
    exp_out = atanh_ref(din);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    data_in  = din;
    tick();
    in_valid = 1'b0;
    data_in  = 13'($urandom);
    lat = 0;
    while (lat < 200) begin
      c_en     = (stall_len > 0 && lat >= stall_at && lat < stall_at + stall_len) ? 1'b0 : 1'b1;
      in_valid = 1'($urandom);
      tick();
      lat++;
      if (out_valid) break;
    end
    c_en     = 1'b1;
    in_valid = 1'b0;
    check_eq("latency", 32'(lat), 32'(9 + stall_len));
    check_eq("data_out", 32'(data_out), 32'(exp_out));
    check_eq("in_ready_busy", 32'(in_ready), 32'd0);
    for (int i = 0; i < bp_cycles; i++) begin
      tick();
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
      check_eq("bp_data_out", 32'(data_out), 32'(exp_out));
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("post_hs_out_valid", 32'(out_valid), 32'd0);
    check_eq("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_data_out"}, 32'(data_out), 32'd0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [12:0] directed [10];
    int          waited;
    directed = '{13'd128, 13'd384, 13'h1E40, 13'd460, 13'd480, 13'd510, 13'd511,
                 13'd4095, 13'h1000, 13'd0};

    reset = 1'b1; c_en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
    repeat (2) tick();
    reset = 1'b0;
    check_reset_state("reset");

    foreach (directed[i]) run_txn(directed[i], 0, 0, 0);

    // Long consumer backpressure, then a mid-search clock-enable freeze.
    run_txn(13'd300, 0, 0, 20);
    run_txn(13'h1F00, 3, 5, 0);

    // Reset during the search, with c_en low to show reset still wins.
    in_valid = 1'b1; data_in = 13'd1000;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1; c_en = 1'b0;
    tick();
    reset = 1'b0; c_en = 1'b1;
    check_reset_state("rst_search");
    run_txn(13'd200, 0, 0, 0);

    // Reset while a result is waiting in DONE.
    in_valid = 1'b1; data_in = 13'd450;
    tick();
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 50) begin
      tick();
      waited++;
    end
    check_eq("done_reached", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst_done");
    run_txn(13'h1800, 0, 0, 1);

    for (int k = 0; k < 300; k++) begin
      logic [12:0] d;
      int          sat, sln;
      d = 13'($urandom_range(0, 8191));
      if ($urandom_range(0, 3) == 0) begin
        sat = $urandom_range(0, 8);
        sln = $urandom_range(1, 4);
      end else begin
        sat = 0;
        sln = 0;
      end
      run_txn(d, sat, sln, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
